// File: rtl/button_pkg.sv
// Shared constants, FSM state type and counter-width helper for the button conditioner.
package button_pkg;

  // Defaults sized for a 100 MHz system clock.
  localparam int DEF_NUM_BTNS        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms
  localparam int DEF_REPEAT_DELAY    = 50000000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 10000000;  // 100 ms

  typedef enum logic [1:0] {
    RELEASED,
    HELD_DELAY,
    REPEATING
  } btn_state_e;

  // Bits needed for a counter running 0..max_count-1, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count <= 1) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce counter, press/hold FSM with auto-repeat.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic dpb,
  output logic scen,
  output logic mcen,
  output logic ccen
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(REPEAT_DELAY);
  localparam int RW = cnt_width(REPEAT_PERIOD);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_PERIOD - 1);

  // Pad level meaning "not pressed"; the synchroniser resets to it so reset exit is quiet.
  localparam logic PAD_IDLE = (ACTIVE_LOW != 0);

  logic            sync1_reg, sync2_reg;
  logic            level;
  logic            deb_reg;
  logic [DW-1:0]   db_cnt_reg;

  btn_state_e      state_reg, state_next;
  logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [RW-1:0]   rep_cnt_reg, rep_cnt_next;
  logic            dpb_reg, dpb_next;
  logic            scen_reg, scen_next;
  logic            mcen_reg, mcen_next;
  logic            ccen_reg, ccen_next;

  // Polarity is normalised after the synchroniser, so level is 1 when pressed.
  assign level = sync2_reg ^ PAD_IDLE;

  // Two-flop synchroniser for the asynchronous pad.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= PAD_IDLE;
      sync2_reg <= PAD_IDLE;
    end else begin
      sync1_reg <= button;
      sync2_reg <= sync1_reg;
    end
  end

  // Debounce: the level must differ for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_reg    <= 1'b0;
      db_cnt_reg <= '0;
    end else if (level == deb_reg) begin
      db_cnt_reg <= '0;
    end else if (db_cnt_reg == DB_LAST) begin
      deb_reg    <= ~deb_reg;
      db_cnt_reg <= '0;
    end else begin
      db_cnt_reg <= db_cnt_reg + 1'b1;
    end
  end

  // FSM and output registers; all outputs leave this module straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RELEASED;
      hold_cnt_reg <= '0;
      rep_cnt_reg  <= '0;
      dpb_reg      <= 1'b0;
      scen_reg     <= 1'b0;
      mcen_reg     <= 1'b0;
      ccen_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      rep_cnt_reg  <= rep_cnt_next;
      dpb_reg      <= dpb_next;
      scen_reg     <= scen_next;
      mcen_reg     <= mcen_next;
      ccen_reg     <= ccen_next;
    end
  end

  // Next-state and next-output logic; a debounced release overrides every state.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    rep_cnt_next  = rep_cnt_reg;
    dpb_next      = deb_reg;
    scen_next     = 1'b0;
    mcen_next     = 1'b0;
    ccen_next     = 1'b0;

    if (!deb_reg) begin
      state_next    = RELEASED;
      hold_cnt_next = '0;
      rep_cnt_next  = '0;
    end else begin
      case (state_reg)
        RELEASED: begin
          state_next    = HELD_DELAY;
          scen_next     = 1'b1;
          mcen_next     = 1'b1;
          hold_cnt_next = '0;
          rep_cnt_next  = '0;
        end
        HELD_DELAY: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            // hold_cnt stays parked at its last value from here on.
            state_next   = REPEATING;
            mcen_next    = 1'b1;
            ccen_next    = 1'b1;
            rep_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        REPEATING: begin
          ccen_next = 1'b1;
          if (rep_cnt_reg == REP_LAST) begin
            rep_cnt_next = '0;
            mcen_next    = 1'b1;
          end else begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = RELEASED;
        end
      endcase
    end
  end

  assign dpb  = dpb_reg;
  assign scen = scen_reg;
  assign mcen = mcen_reg;
  assign ccen = ccen_reg;

endmodule

// File: rtl/button_conditioner.sv
// N independent push-button channels: debounced level, press pulse, auto-repeat and hold enable.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BTNS        = DEF_NUM_BTNS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] buttons,
  output logic [NUM_BTNS-1:0] DPBs,
  output logic [NUM_BTNS-1:0] SCENs,
  output logic [NUM_BTNS-1:0] MCENs,
  output logic [NUM_BTNS-1:0] CCENs
);

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .button(buttons[gi]),
      .dpb   (DPBs[gi]),
      .scen  (SCENs[gi]),
      .mcen  (MCENs[gi]),
      .ccen  (CCENs[gi])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, plus a 1-channel active-low instance.
module tb_button_conditioner;

  localparam int NB  = 4;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = 2 + DB;   // raw change to outputs
  localparam int REP = LAT + RD; // first auto-repeat offset

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] buttons;
  logic [NB-1:0] dpbs, scens, mcens, ccens;
  logic [0:0]    pad_al;
  logic [0:0]    al_dpb, al_scen, al_mcen, al_ccen;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset(reset), .buttons(buttons),
    .DPBs(dpbs), .SCENs(scens), .MCENs(mcens), .CCENs(ccens)
  );

  button_conditioner #(
    .NUM_BTNS(1), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .reset(reset), .buttons(pad_al),
    .DPBs(al_dpb), .SCENs(al_scen), .MCENs(al_mcen), .CCENs(al_ccen)
  );

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Expected per-channel outputs k cycles after the press edge, release at rel.
  function automatic logic e_dpb(input int k, input int rel);
    return (k >= LAT) && (k < rel + LAT);
  endfunction
  function automatic logic e_scen(input int k);
    return (k == LAT);
  endfunction
  function automatic logic e_mcen(input int k, input int rel);
    return (k == LAT) || ((k >= REP) && (k < rel + LAT) && ((k - REP) % RP == 0));
  endfunction
  function automatic logic e_ccen(input int k, input int rel);
    return (k >= REP) && (k < rel + LAT);
  endfunction

  task automatic check_outs(input string name, input int t,
                            input logic [3:0] ed, input logic [3:0] es,
                            input logic [3:0] em, input logic [3:0] ec);
    check_eq($sformatf("%s t=%0d dpb", name, t), dpbs, ed);
    check_eq($sformatf("%s t=%0d scen", name, t), scens, es);
    check_eq($sformatf("%s t=%0d mcen", name, t), mcens, em);
    check_eq($sformatf("%s t=%0d ccen", name, t), ccens, ec);
  endtask

  task automatic check_al(input string name, input int t,
                          input logic d, input logic s, input logic m, input logic c);
    check_eq($sformatf("%s t=%0d al_dpb", name, t), 4'(al_dpb), 4'(d));
    check_eq($sformatf("%s t=%0d al_scen", name, t), 4'(al_scen), 4'(s));
    check_eq($sformatf("%s t=%0d al_mcen", name, t), 4'(al_mcen), 4'(m));
    check_eq($sformatf("%s t=%0d al_ccen", name, t), 4'(al_ccen), 4'(c));
  endtask

  initial begin
    logic [3:0] ed, es, em, ec;
    logic       b;
    int         k;

    reset   = 1'b1;
    buttons = '0;
    pad_al  = 1'b1;
    idle(3);
    check_outs("reset", 0, 4'b0, 4'b0, 4'b0, 4'b0);
    check_al("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step();
      check_outs("idle", t, 4'b0, 4'b0, 4'b0, 4'b0);
      check_al("idle_al", t, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    $display("transaction reset/idle done checks=%0d", checks);

    // Hold channel 0 for 40 cycles, then release.
    for (int t = 0; t <= 50; t++) begin
      buttons[0] = (t < 40);
      step();
      ed = {3'b0, e_dpb(t, 40)};
      es = {3'b0, e_scen(t)};
      em = {3'b0, e_mcen(t, 40)};
      ec = {3'b0, e_ccen(t, 40)};
      check_outs("hold_release", t, ed, es, em, ec);
    end
    $display("transaction hold_release done checks=%0d", checks);
    idle(12);

    // Short 3-cycle pulse is rejected.
    for (int t = 0; t <= 15; t++) begin
      buttons[0] = (t < 3);
      step();
      check_outs("glitch", t, 4'b0, 4'b0, 4'b0, 4'b0);
    end
    $display("transaction glitch done checks=%0d", checks);
    idle(12);

    // Bouncing channel 2 settles high at cycle 12.
    for (int t = 0; t <= 20; t++) begin
      buttons[2] = (t < 12) ? (((t / 2) % 2) == 0) : 1'b1;
      step();
      b  = (t >= 18);
      ed = {1'b0, b, 2'b0};
      b  = (t == 18);
      es = {1'b0, b, 2'b0};
      check_outs("bounce", t, ed, es, es, 4'b0);
    end
    buttons = '0;
    $display("transaction bounce done checks=%0d", checks);
    idle(12);

    // Channels 1 and 3 pressed together.
    for (int t = 0; t <= 30; t++) begin
      buttons = 4'b1010;
      step();
      b  = e_dpb(t, 1000);  ed = {b, 1'b0, b, 1'b0};
      b  = e_scen(t);       es = {b, 1'b0, b, 1'b0};
      b  = e_mcen(t, 1000); em = {b, 1'b0, b, 1'b0};
      b  = e_ccen(t, 1000); ec = {b, 1'b0, b, 1'b0};
      check_outs("dual", t, ed, es, em, ec);
    end
    buttons = '0;
    $display("transaction dual done checks=%0d", checks);
    idle(12);

    // Reset asserted for edges 20 and 21 while channel 0 is held.
    for (int t = 0; t <= 34; t++) begin
      buttons[0] = 1'b1;
      reset      = (t == 20) || (t == 21);
      step();
      if (t >= 20 && t < 22) begin
        check_outs("midreset", t, 4'b0, 4'b0, 4'b0, 4'b0);
      end else begin
        k  = (t < 20) ? t : t - 22;
        ed = {3'b0, e_dpb(k, 1000)};
        es = {3'b0, e_scen(k)};
        em = {3'b0, e_mcen(k, 1000)};
        ec = {3'b0, e_ccen(k, 1000)};
        check_outs("midreset", t, ed, es, em, ec);
      end
    end
    reset   = 1'b0;
    buttons = '0;
    $display("transaction midreset done checks=%0d", checks);
    idle(12);

    // Active-low pad pulled low.
    for (int t = 0; t <= 12; t++) begin
      pad_al = 1'b0;
      step();
      check_al("active_low", t, e_dpb(t, 1000), e_scen(t), e_mcen(t, 1000), e_ccen(t, 1000));
    end
    $display("transaction active_low done checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Parametrised N-channel push-button conditioner. It is the successor of the fixed four-button input interface that feeds game logic. Each channel synchronises a raw pad, debounces it, and produces four signals:
- DPB: debounced level.
- SCEN: single-cycle press pulse.
- MCEN: auto-repeat pulse train.
- CCEN: continuous enable after a hold delay.

It sits between the board buttons and game/menu logic. Everything runs on the system clock.

Parameters:
NUM_BTNS, 4, number of independent button channels
DEBOUNCE_CYCLES, 1000000, stable cycles required before DPB changes (>=1)
REPEAT_DELAY, 50000000, cycles after press before auto-repeat starts (>=1)
REPEAT_PERIOD, 10000000, cycles between auto-repeat MCEN pulses (>=1)
ACTIVE_LOW, 0, 1 = raw inputs are active-low and are inverted internally

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
buttons  input  NUM_BTNS  raw asynchronous button pads
DPBs  output  NUM_BTNS  debounced pressed level
SCENs  output  NUM_BTNS  one-cycle pulse on debounced press
MCENs  output  NUM_BTNS  press pulse plus auto-repeat pulses while held
CCENs  output  NUM_BTNS  high every cycle while held beyond REPEAT_DELAY

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset: all outputs 0; all counters 0; synchroniser flops loaded with the inactive pad level, so there is no spurious press at reset exit.
- Synchroniser: 2-flop per channel. When ACTIVE_LOW=1, inversion is applied after the synchroniser.
- Debounce: per-channel counter cnt.
  - sync level equal to DPB: cnt cleared.
  - sync level differs: cnt increments.
  - cnt reaches DEBOUNCE_CYCLES-1 while still differing: DPB toggles and cnt clears on that edge.
  - Resulting latency from a stable raw change to a DPB change: exactly 2+DEBOUNCE_CYCLES cycles.
  - Any reversal before that point restarts the count, so glitches shorter than DEBOUNCE_CYCLES are suppressed.
- Per-channel FSM with states RELEASED, HELD_DELAY, REPEATING.
  - RELEASED -> HELD_DELAY on the DPB rise. SCEN=1 and MCEN=1 for that one cycle. hold_cnt=0.
  - HELD_DELAY: hold_cnt increments each cycle. When hold_cnt == REPEAT_DELAY-1 -> REPEATING, with MCEN=1 and CCEN=1 from the first REPEATING cycle.
  - REPEATING:
    - CCEN stays high.
    - rep_cnt counts 0..REPEAT_PERIOD-1 and wraps.
    - MCEN pulses when rep_cnt wraps to 0, i.e. every REPEAT_PERIOD cycles after the first repeat pulse.
    - REPEAT_PERIOD=1 gives MCEN high every cycle.
  - Any state -> RELEASED on the DPB fall. SCEN, MCEN and CCEN are 0 in the same cycle DPB reads 0, and all counters clear.
- Pulses: SCEN is exactly one cycle per debounced press regardless of hold length.
- Press pulse timing: MCEN pulses at hold offsets 0, REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, ...
- Counter widths: $clog2 of the respective parameter (minimum 1 bit). hold_cnt saturates in REPEATING and never wraps.
- Channels are fully independent; simultaneous presses have no interaction.
- Reset mid-hold clears everything on the next edge. A still-held button is re-detected after the full 2+DEBOUNCE_CYCLES latency.
- All outputs are registered; no combinational path from buttons to any output.

Decomposition:
- Package button_pkg:
  - default constants (DEBOUNCE/REPEAT values for 100 MHz);
  - FSM state enum {RELEASED, HELD_DELAY, REPEATING};
  - a width helper function.
- Sub-module button_channel: synchroniser, debounce counter, FSM and repeat counters for one button.
- Top level button_conditioner is a generate loop of NUM_BTNS instances.

Test Plan:
(Bench parameters: NUM_BTNS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=0. Cycle 0 is the first edge sampling a raw change.)
1. buttons[0] raised at cycle 0, held 40 cycles -> DPBs[0] high from cycle 6; SCENs[0] only at 6; MCENs[0] at 6,16,19,22,25,...; CCENs[0] high from 16.
2. buttons[0] high for 3 cycles then low -> DPBs/SCENs/MCENs/CCENs stay 0 throughout.
3. buttons[2] toggles every 2 cycles for 12 cycles, then stays high from cycle 12 -> exactly one SCENs[2] pulse, at cycle 18.
4. Release after scenario 1 at cycle 40 -> DPBs[0], MCENs[0], CCENs[0] fall together at cycle 46; no SCEN on release.
5. buttons[1] and buttons[3] raised together -> identical timing to scenario 1 on both channels; channels 0 and 2 stay 0.
6. reset pulsed at cycle 20 while buttons[0] held -> all outputs 0 at cycle 21; reset released at 22, button still held -> SCENs[0] at cycle 28.
7. ACTIVE_LOW=1 instance with pads idle high through reset -> no outputs. Pad driven low -> SCEN after 6 cycles.
